// File: rtl/apb_bcd_alu.sv
// Packed-BCD add/subtract engine behind an APB slave.
// Every transfer takes one wait state; the datapath processes one decimal digit per clock.
module apb_bcd_alu #(
    parameter int unsigned DIGITS    = 4,
    parameter logic [31:0] CTRL_ADDR = 32'h00,
    parameter logic [31:0] OPA_ADDR  = 32'h04,
    parameter logic [31:0] OPB_ADDR  = 32'h08,
    parameter logic [31:0] RES_ADDR  = 32'h0C,
    parameter logic [31:0] STAT_ADDR = 32'h10
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        CALC
    } state_t;

    state_t        state;
    logic [W-1:0]  opa;
    logic [W-1:0]  opb;
    logic [W-1:0]  res;
    logic          mode;
    logic          busy;
    logic          done;
    logic          cout;
    logic          invalid;
    logic          start_pend;
    logic          carry;
    logic [IW-1:0] idx;

    logic          access;
    logic          is_ctrl;
    logic          is_opa;
    logic          is_opb;
    logic          is_res;
    logic          is_stat;
    logic          mapped;
    logic          xfer_err;
    logic          wr_ok;
    logic [31:0]   rd_val;
    logic          operands_bad;
    logic [3:0]    dig_a;
    logic [3:0]    dig_b;
    logic [3:0]    dig_out;
    logic          dig_carry;
    logic [4:0]    add_raw;
    logic [4:0]    sub_need;
    logic          unused_pwdata;

    assign unused_pwdata = ^PWDATA;

    // Address decode, error classification and read mux for the current access phase
    always_comb begin
        access  = PSEL & PENABLE & ~PREADY;
        is_ctrl = (PADDR == CTRL_ADDR);
        is_opa  = (PADDR == OPA_ADDR);
        is_opb  = (PADDR == OPB_ADDR);
        is_res  = (PADDR == RES_ADDR);
        is_stat = (PADDR == STAT_ADDR);
        mapped  = is_ctrl | is_opa | is_opb | is_res | is_stat;

        // start_pend counts as busy so a request cannot slip in before BUSY rises
        xfer_err = ~mapped
                 | (PWRITE & (is_res | is_stat))
                 | (PWRITE & (busy | start_pend) & (is_ctrl | is_opa | is_opb));
        wr_ok    = access & PWRITE & ~xfer_err;

        rd_val = '0;
        if (is_ctrl) begin
            rd_val = {30'b0, mode, 1'b0};
        end else if (is_opa) begin
            rd_val = 32'(opa);
        end else if (is_opb) begin
            rd_val = 32'(opb);
        end else if (is_res) begin
            rd_val = 32'(res);
        end else if (is_stat) begin
            rd_val = {28'b0, invalid, cout, done, busy};
        end
    end

    // Operand validation: any nibble above 9 makes the operation invalid
    always_comb begin
        operands_bad = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if ((opa[k*4 +: 4] > 4'd9) || (opb[k*4 +: 4] > 4'd9)) begin
                operands_bad = 1'b1;
            end
        end
    end

    // Single-digit BCD adder/subtractor for the digit selected by idx
    always_comb begin
        dig_a     = opa[32'(idx)*4 +: 4];
        dig_b     = opb[32'(idx)*4 +: 4];
        add_raw   = 5'(dig_a) + 5'(dig_b) + 5'(carry);
        sub_need  = 5'(dig_b) + 5'(carry);
        dig_out   = '0;
        dig_carry = 1'b0;
        if (mode) begin
            if (add_raw > 5'd9) begin
                dig_out   = 4'(add_raw - 5'd10);
                dig_carry = 1'b1;
            end else begin
                dig_out   = 4'(add_raw);
            end
        end else begin
            if (5'(dig_a) < sub_need) begin
                dig_out   = 4'(5'(dig_a) + 5'd10 - sub_need);
                dig_carry = 1'b1;
            end else begin
                dig_out   = 4'(5'(dig_a) - sub_need);
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state      <= IDLE;
            opa        <= '0;
            opb        <= '0;
            res        <= '0;
            mode       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cout       <= 1'b0;
            invalid    <= 1'b0;
            start_pend <= 1'b0;
            carry      <= 1'b0;
            idx        <= '0;
            PRDATA     <= '0;
            PREADY     <= 1'b0;
            PSLVERR    <= 1'b0;
        end else begin
            // APB response: one wait state, then a single PREADY cycle
            PREADY     <= access;
            PSLVERR    <= access & xfer_err;
            start_pend <= 1'b0;
            if (access) begin
                PRDATA <= (PWRITE || xfer_err) ? '0 : rd_val;
            end

            case (state)
                IDLE: begin
                    if (start_pend) begin
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        cout    <= 1'b0;
                        invalid <= 1'b0;
                        state   <= CHECK;
                    end
                end
                CHECK: begin
                    if (operands_bad) begin
                        invalid <= 1'b1;
                        res     <= '0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        idx   <= '0;
                        carry <= 1'b0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    res[32'(idx)*4 +: 4] <= dig_out;
                    carry                <= dig_carry;
                    if (idx == LAST_IDX) begin
                        cout  <= dig_carry;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Register writes; errors never reach here, so busy operands stay frozen
            if (wr_ok) begin
                if (is_ctrl) begin
                    mode       <= PWDATA[1];
                    start_pend <= PWDATA[0];
                end
                if (is_opa) begin
                    opa <= PWDATA[W-1:0];
                end
                if (is_opb) begin
                    opb <= PWDATA[W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_bcd_alu.sv
// Randomized and directed bench for apb_bcd_alu; expectations come from a decimal-arithmetic
// model plus a cycle timeline of when BUSY/DONE and each result digit become visible.
module tb_apb_bcd_alu;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 4 * DIGITS;
    localparam logic [31:0] A_CTRL = 32'h00;
    localparam logic [31:0] A_OPA  = 32'h04;
    localparam logic [31:0] A_OPB  = 32'h08;
    localparam logic [31:0] A_RES  = 32'h0C;
    localparam logic [31:0] A_STAT = 32'h10;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model state: programmed registers and the timeline of the last started operation
    logic [W-1:0] m_opa       = '0;
    logic [W-1:0] m_opb       = '0;
    logic [W-1:0] m_old       = '0;
    logic [W-1:0] m_new       = '0;
    logic         m_mode      = 1'b0;
    logic         m_valid     = 1'b0;
    logic         m_cout      = 1'b0;
    logic [31:0]  m_prev_stat = '0;
    bit           m_started   = 1'b0;
    int           m_ps        = 0;

    apb_bcd_alu #(.DIGITS(DIGITS)) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int bcd_to_int(input logic [W-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int_to_bcd(input int n);
        logic [W-1:0] r = '0;
        int x = n;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit all_decimal(input logic [W-1:0] v);
        for (int i = 0; i < DIGITS; i++) if (v[i*4 +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    // STAT as held after clock edge t: BUSY from edge ps+1 for DIGITS+1 cycles (1 if invalid)
    function automatic logic [31:0] exp_stat(input int t);
        int lat;
        if (!m_started) return 32'h0;
        if (t <= m_ps) return m_prev_stat;
        lat = m_valid ? DIGITS + 1 : 1;
        if (t <= m_ps + lat) return 32'h1;
        return {28'b0, ~m_valid, m_cout, 1'b1, 1'b0};
    endfunction

    // RES as held after clock edge t: digit i lands at edge ps+3+i
    function automatic logic [W-1:0] exp_res(input int t);
        logic [W-1:0] r;
        int ndone;
        r = m_old;
        if (!m_started) return m_old;
        if (!m_valid) return (t >= m_ps + 2) ? '0 : m_old;
        ndone = t - (m_ps + 2);
        for (int i = 0; i < DIGITS; i++) if (i < ndone) r[i*4 +: 4] = m_new[i*4 +: 4];
        return r;
    endfunction

    task automatic model_start(input int e);
        int a, b, s, p;
        m_prev_stat = exp_stat(e);
        m_old       = exp_res(e);
        p = 1;
        for (int i = 0; i < DIGITS; i++) p = p * 10;
        m_valid = all_decimal(m_opa) && all_decimal(m_opb);
        if (m_valid) begin
            a = bcd_to_int(m_opa);
            b = bcd_to_int(m_opb);
            if (m_mode) begin
                s = a + b;
                m_cout = (s >= p);
                s = s % p;
            end else begin
                s = a - b;
                m_cout = (s < 0);
                if (s < 0) s = s + p;
            end
            m_new = int_to_bcd(s);
        end else begin
            m_new  = '0;
            m_cout = 1'b0;
        end
        m_ps      = e;
        m_started = 1'b1;
    endtask

    task automatic model_reset();
        m_opa = '0; m_opb = '0; m_old = '0; m_new = '0;
        m_mode = 1'b0; m_valid = 1'b0; m_cout = 1'b0;
        m_prev_stat = '0; m_started = 1'b0;
    endtask

    // One APB transfer starting at a falling edge; e is the edge that raised PREADY
    task automatic xfer(input bit wr_en, input logic [31:0] addr, input logic [31:0] data,
                        output logic [31:0] rdata, output logic err, output int e);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr_en; PADDR = addr; PWDATA = data;
        @(negedge PCLK);
        chk("pready_setup", 32'(PREADY), 32'h0);
        PENABLE = 1'b1;
        @(negedge PCLK);
        chk("pready_one_wait", 32'(PREADY), 32'h1);
        for (int k = 0; k < 8 && !PREADY; k++) @(negedge PCLK);
        if (!PREADY) begin
            $display("FAIL pready_timeout: got 0, expected 1 (addr %h)", addr);
            $fatal(1, "PREADY never rose");
        end
        rdata = PRDATA;
        err   = PSLVERR;
        e     = cyc;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, output logic err, output int e);
        logic [31:0] rdata, st;
        bit exp_err;
        xfer(1'b1, addr, data, rdata, err, e);
        st = exp_stat(e - 1);
        if (addr == A_CTRL || addr == A_OPA || addr == A_OPB) exp_err = st[0];
        else exp_err = 1'b1;
        chk($sformatf("wr_err@%h", addr), 32'(err), 32'(exp_err));
        if (!exp_err) begin
            if (addr == A_OPA) m_opa = data[W-1:0];
            if (addr == A_OPB) m_opb = data[W-1:0];
            if (addr == A_CTRL) begin
                m_mode = data[1];
                if (data[0]) model_start(e);
            end
        end
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data, output logic err);
        logic [31:0] exp;
        bit exp_err;
        int e;
        xfer(1'b0, addr, 32'h0, data, err, e);
        exp_err = 1'b0;
        case (addr)
            A_CTRL:  exp = {30'b0, m_mode, 1'b0};
            A_OPA:   exp = 32'(m_opa);
            A_OPB:   exp = 32'(m_opb);
            A_RES:   exp = 32'(exp_res(e - 1));
            A_STAT:  exp = exp_stat(e - 1);
            default: begin exp = 32'h0; exp_err = 1'b1; end
        endcase
        chk($sformatf("rd_err@%h", addr), 32'(err), 32'(exp_err));
        if (!exp_err) chk($sformatf("rd_data@%h", addr), data, exp);
    endtask

    task automatic do_reset(input int n);
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        repeat (n) @(negedge PCLK);
        chk("rst_pready", 32'(PREADY), 32'h0);
        chk("rst_pslverr", 32'(PSLVERR), 32'h0);
        chk("rst_prdata", PRDATA, 32'h0);
        PRESET = 1'b0;
        model_reset();
    endtask

    // Poll STAT (optionally interleaving RES reads) until DONE with BUSY low
    task automatic wait_done(input int gap, input bit jitter, input bit mix_res);
        logic [31:0] d;
        logic err;
        bit seen = 1'b0;
        repeat (gap) @(negedge PCLK);
        for (int k = 0; k < 30 && !seen; k++) begin
            if (jitter && $urandom_range(1) == 1) @(negedge PCLK);
            if (mix_res && $urandom_range(2) == 0) begin
                rd(A_RES, d, err);
            end else begin
                rd(A_STAT, d, err);
                seen = d[1] & ~d[0];
            end
        end
        chk("done_reached", 32'(seen), 32'h1);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic md, input int gap);
        logic err;
        int e;
        wr(A_OPA, a, err, e);
        wr(A_OPB, b, err, e);
        wr(A_CTRL, {30'b0, md, 1'b1}, err, e);
        wait_done(gap, 1'b0, 1'b0);
    endtask

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] v;
        for (int i = 0; i < DIGITS; i++) v[i*4 +: 4] = 4'($urandom_range(9));
        if ($urandom_range(5) == 0) v[$urandom_range(DIGITS - 1)*4 +: 4] = 4'($urandom_range(15, 10));
        return v;
    endfunction

    initial begin
        logic [31:0] d, wd;
        logic [31:0] bad_addrs [4];
        logic err;
        int e;
        logic md;

        bad_addrs = '{32'h14, 32'h20, 32'h01, 32'hFFFF_FFF0};
        do_reset(3);

        // Reset state of every register
        rd(A_CTRL, d, err); chk("rst_ctrl_lit", d, 32'h0);
        rd(A_OPA, d, err);  chk("rst_opa_lit", d, 32'h0);
        rd(A_RES, d, err);  chk("rst_res_lit", d, 32'h0);
        rd(A_STAT, d, err); chk("rst_stat_lit", d, 32'h0);

        // 500 - 123, polled on both cycle parities to cover every BUSY cycle
        run_op(32'h0500, 32'h0123, 1'b0, 0);
        rd(A_RES, d, err);  chk("sub_res_lit", d, 32'h0377);
        rd(A_STAT, d, err); chk("sub_stat_lit", d, 32'h2);
        run_op(32'h0500, 32'h0123, 1'b0, 1);
        rd(A_RES, d, err);  chk("sub2_res_lit", d, 32'h0377);

        // Negative difference leaves ten's complement with borrow out
        run_op(32'h0100, 32'h0200, 1'b0, 0);
        rd(A_RES, d, err);  chk("neg_res_lit", d, 32'h9900);
        rd(A_STAT, d, err); chk("neg_stat_lit", d, 32'h6);
        rd(A_STAT, d, err); chk("done_sticky_lit", d, 32'h6);

        // Add overflow wraps modulo 10^DIGITS
        run_op(32'h9999, 32'h0001, 1'b1, 0);
        rd(A_RES, d, err);  chk("ovf_res_lit", d, 32'h0000);
        rd(A_STAT, d, err); chk("ovf_stat_lit", d, 32'h6);

        // MODE-only write leaves status alone
        wr(A_CTRL, 32'h2, err, e);
        rd(A_CTRL, d, err); chk("mode_only_lit", d, 32'h2);
        rd(A_STAT, d, err); chk("mode_only_stat_lit", d, 32'h6);

        // Invalid operand nibble
        run_op(32'h00A0, 32'h0000, 1'b0, 0);
        rd(A_RES, d, err);  chk("inv_res_lit", d, 32'h0);
        rd(A_STAT, d, err); chk("inv_stat_lit", d, 32'hA);

        // Writes while busy and unmapped accesses are rejected
        wr(A_OPA, 32'h1234, err, e);
        wr(A_OPB, 32'h0012, err, e);
        wr(A_CTRL, 32'h1, err, e);
        wr(A_OPA, 32'h5555, err, e);    chk("busy_wr_err_lit", 32'(err), 32'h1);
        rd(A_OPA, d, err);              chk("busy_opa_kept_lit", d, 32'h1234);
        rd(32'h20, d, err);             chk("unmapped_err_lit", 32'(err), 32'h1);
        wait_done(0, 1'b0, 1'b1);
        rd(A_RES, d, err);              chk("busy_res_lit", d, 32'h1222);
        wr(A_RES, 32'h1, err, e);       chk("res_wr_err_lit", 32'(err), 32'h1);

        // Reset mid-calculation while digit 2 is in progress
        wr(A_OPA, 32'h4321, err, e);
        wr(A_OPB, 32'h1111, err, e);
        wr(A_CTRL, 32'h3, err, e);
        while (cyc < e + 4) @(negedge PCLK);
        do_reset(1);
        rd(A_OPA, d, err);  chk("mid_rst_opa_lit", d, 32'h0);
        rd(A_OPB, d, err);  chk("mid_rst_opb_lit", d, 32'h0);
        rd(A_RES, d, err);  chk("mid_rst_res_lit", d, 32'h0);
        rd(A_STAT, d, err); chk("mid_rst_stat_lit", d, 32'h0);
        rd(A_CTRL, d, err); chk("mid_rst_ctrl_lit", d, 32'h0);
        run_op(32'h0042, 32'h0017, 1'b1, 0);
        rd(A_RES, d, err);  chk("post_rst_res_lit", d, 32'h0059);
        rd(A_STAT, d, err); chk("post_rst_stat_lit", d, 32'h2);

        // Randomized operations against the model
        for (int it = 0; it < 40; it++) begin
            wd = $urandom; wd[W-1:0] = rand_bcd();
            wr(A_OPA, wd, err, e);
            wd = $urandom; wd[W-1:0] = rand_bcd();
            wr(A_OPB, wd, err, e);
            if ($urandom_range(3) == 0) begin
                wr(A_CTRL, {30'b0, 1'($urandom_range(1)), 1'b0}, err, e);
                rd(A_CTRL, d, err);
            end
            if ($urandom_range(3) == 0) rd(A_OPB, d, err);
            md = 1'($urandom_range(1));
            wr(A_CTRL, {30'b0, md, 1'b1}, err, e);
            if ($urandom_range(2) == 0) wr(A_OPB, $urandom, err, e);
            if ($urandom_range(3) == 0) rd(bad_addrs[$urandom_range(3)], d, err);
            if ($urandom_range(4) == 0) wr(A_STAT, $urandom, err, e);
            wait_done(0, 1'b1, 1'b1);
            rd(A_RES, d, err);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
